reg_fetch_issue: RTL and testbench
==================================

Name: reg_fetch_issue

Overview:
Dual-pipe register-fetch and issue stage of the SPU. It consumes the decoded pair held by the ID/REG pipeline register and reads a 128x128 register file that lives inside this block. A busy-bit scoreboard detects RAW and WAW hazards, and the block issues operands in order to the two execution pipes. When a hazard blocks issue it raises stall_o back toward decode.

Parameters:
NUM_REGS, 128, architectural register count (index width = $clog2(NUM_REGS) = 7)
DATA_W, 128, register/operand width
IMM_W, 18, widest immediate field; narrower immediates arrive zero-extended

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
flush_i  in  1  discard held pair (branch redirect)
valid_i  in  [1:0]  pipe p instruction present
ra_i, rb_i, rc_i  in  [1:0][6:0]  source register indices
src_use_i  in  [1:0][2:0]  per pipe {RC,RB,RA} actually read
rt_i  in  [1:0][6:0]  destination index
we_i  in  [1:0]  regWriteEnable
ctrl_i  in  [1:0][3:0]  execution control code
imm_i  in  [1:0][17:0]  immediate
stall_o  out  1  combinational; decode and ID/REG hold current pair
wb_en_i  in  [1:0]  writeback enable per pipe
wb_addr_i  in  [1:0][6:0]  writeback index
wb_data_i  in  [1:0][127:0]  writeback data
ex_valid_o  out  [1:0]  issued this cycle (registered)
ex_opa_o, ex_opb_o, ex_opc_o  out  [1:0][127:0]  operands
ex_rt_o  out  [1:0][6:0]; ex_we_o  out  [1:0]; ex_ctrl_o  out  [1:0][3:0]; ex_imm_o  out  [1:0][17:0]

Behaviour:
- Reset (synchronous, active-high): all ex_* outputs are 0. Scoreboard busy bits are 0. FSM goes to PAIR. Register file contents are not reset.
- Latency: issue at edge N; ex_* are valid in cycle N+1. Operands come from the register file read in cycle N.
- Busy bit: set at the edge an instruction with we=1 issues, for its rt. Cleared at the edge where wb_en_i writes that index. If set and clear hit the same index on the same edge, set wins.
- Register file writes: wb_data_i is written at the edge. If both wb ports write the same index, port 1 (pipe2) wins.
- hz1 = valid1 & (any used source busy | (we1 & busy[rt1])).
- hz2 = valid2 & (any used source busy | (we2 & busy[rt2]) | intra), where intra (PAIR state only) = valid1 & we1 & (used source2 == rt1 | (we2 & rt2 == rt1)).
- An invalid pipe never has a hazard and never issues.
- FSM PAIR:
  - !hz1 & !hz2: issue both; stall_o=0.
  - !hz1 & hz2: issue pipe1 only; stall_o=1; go to SPLIT.
  - hz1: issue nothing; stall_o=1 (in-order issue).
  - If valid1=0 and valid2=1 with no hazard, pipe2 issues alone.
- FSM SPLIT: pipe1 is never re-issued. Evaluate hz2 without intra; pipe1's busy bit covers that dependency.
  - Clear: issue pipe2, stall_o=0, go to PAIR.
  - Otherwise: stall_o=1.
- flush_i: that cycle, ex_valid_o next = 0 and FSM goes to PAIR. Busy bits are untouched, because in-flight writebacks still arrive. flush_i has priority over issue; reset has priority over flush_i.
- Non-issued pipe: ex_valid_o=0; the other ex_* fields hold their previous values.

Optional Feature:
FORWARD_WB_EN
- Defined:
  - A source whose index matches an active wb port in the same cycle is treated as not busy.
  - Its operand takes wb_data_i, pipe2 port taking priority.
- Undefined:
  - Such a source stalls that cycle.
  - The operand is read from the register file next cycle (one extra stall cycle per RAW).

Decomposition:
- Package spu_pkg holds:
  - constants NUM_REGS, DATA_W, IMM_W, REG_IDX_W;
  - typedef reg_idx_t, data_t, ctrl_t;
  - enum issue_state_e {PAIR, SPLIT}.
- One sub-module, spu_regfile: 128x128, 6 combinational read ports, 2 write ports, optional bypass under FORWARD_WB_EN.
- Scoreboard and FSM stay in reg_fetch_issue.

Test Plan:
- Write r5=0xA, r6=0xB via wb; then pair {pipe1: RA=5,RB=6,RT=7,we=1; pipe2: RA=8} -> both ex_valid_o=1 next cycle; opa1=0xA, opb1=0xB; busy[7]=1.
- Intra-pair RAW: pipe1 RT=9, pipe2 RA=9 -> cycle0: pipe1 issues, stall_o=1. Stall holds until wb_en to r9 (data 0x55). pipe2 then issues with opa2=0x55; without FORWARD_WB_EN, one cycle later.
- Pipe1 RA busy (r3 pending) -> ex_valid_o=2'b00 and stall_o=1 each cycle until r3 writeback; then both pipes issue.
- WAW: pipe1 and pipe2 both write RT=12 -> split issue; pipe2 issues only after r12 is written back.
- flush_i asserted in SPLIT -> ex_valid_o=0 next cycle; FSM PAIR; busy bits of issued pipe1 unchanged.
- Reset asserted mid-SPLIT with busy[4]=1 -> next cycle all outputs 0, busy all clear, stall_o=0 for a hazard-free pair.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU register-fetch / issue stage.
// Optional macro FORWARD_WB_EN enables same-cycle writeback forwarding.
package spu_pkg;
    localparam int NUM_REGS  = 128;
    localparam int DATA_W    = 128;
    localparam int IMM_W     = 18;
    localparam int CTRL_W    = 4;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [CTRL_W-1:0]    ctrl_t;
    typedef logic [IMM_W-1:0]     imm_t;

    typedef enum logic {
        PAIR,
        SPLIT
    } issue_state_e;
endpackage

// File: rtl/reg_fetch_issue_if.sv
// Decode-to-issue bundle: the decoded instruction pair and the stall
// returned to decode. master = decode side, slave = issue stage.
interface reg_fetch_issue_if;
    import spu_pkg::*;

    logic [1:0]     valid_i;
    reg_idx_t [1:0] ra_i;
    reg_idx_t [1:0] rb_i;
    reg_idx_t [1:0] rc_i;
    logic [1:0][2:0] src_use_i;
    reg_idx_t [1:0] rt_i;
    logic [1:0]     we_i;
    ctrl_t [1:0]    ctrl_i;
    imm_t [1:0]     imm_i;
    logic           stall_o;

    modport master (
        output valid_i, ra_i, rb_i, rc_i, src_use_i,
        output rt_i, we_i, ctrl_i, imm_i,
        input  stall_o
    );

    modport slave (
        input  valid_i, ra_i, rb_i, rc_i, src_use_i,
        input  rt_i, we_i, ctrl_i, imm_i,
        output stall_o
    );
endinterface

// File: rtl/spu_regfile.sv
// 128x128 register file: 6 combinational read ports, 2 write ports.
// With FORWARD_WB_EN, reads bypass same-cycle writes (port 1 wins).
module spu_regfile
    import spu_pkg::*;
(
    input  logic           clk,
    input  reg_idx_t [5:0] rd_addr,
    output data_t [5:0]    rd_data,
    input  logic [1:0]     wr_en,
    input  reg_idx_t [1:0] wr_addr,
    input  data_t [1:0]    wr_data
);
    data_t mem [NUM_REGS];

    // Write port 1 is applied last so it wins an address collision
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) mem[wr_addr[p]] <= wr_data[p];
        end
    end

    // Asynchronous read, optionally bypassing the writeback ports
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            rd_data[i] = mem[rd_addr[i]];
`ifdef FORWARD_WB_EN
            if (wr_en[0] && wr_addr[0] == rd_addr[i]) rd_data[i] = wr_data[0];
            if (wr_en[1] && wr_addr[1] == rd_addr[i]) rd_data[i] = wr_data[1];
`endif
        end
    end
endmodule

// File: rtl/reg_fetch_issue.sv
// Dual-pipe register fetch and in-order issue with busy-bit scoreboard.
// Optional macro FORWARD_WB_EN: writeback hits count as ready sources.
module reg_fetch_issue
    import spu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    reg_fetch_issue_if.slave id,
    input  logic [1:0]       wb_en_i,
    input  reg_idx_t [1:0]   wb_addr_i,
    input  data_t [1:0]      wb_data_i,
    output logic [1:0]       ex_valid_o,
    output data_t [1:0]      ex_opa_o,
    output data_t [1:0]      ex_opb_o,
    output data_t [1:0]      ex_opc_o,
    output reg_idx_t [1:0]   ex_rt_o,
    output logic [1:0]       ex_we_o,
    output ctrl_t [1:0]      ex_ctrl_o,
    output imm_t [1:0]       ex_imm_o
);
    issue_state_e          state, state_n;
    logic [NUM_REGS-1:0]   busy, busy_n, src_block;
    reg_idx_t [5:0]        rd_addr;
    data_t [5:0]           rd_data;
    logic [1:0]            src_hit, rt_hit, issue;
    logic                  intra, hz1, hz2, stall;

    spu_regfile u_rf (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wb_en_i),
        .wr_addr (wb_addr_i),
        .wr_data (wb_data_i)
    );

    // Read port p*3+{0,1,2} serves pipe p sources {RA,RB,RC}
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_addr[3*p]   = id.ra_i[p];
            rd_addr[3*p+1] = id.rb_i[p];
            rd_addr[3*p+2] = id.rc_i[p];
        end
    end

    // Registers that make a source wait this cycle
`ifdef FORWARD_WB_EN
    logic [NUM_REGS-1:0] wb_hit;
    always_comb begin
        wb_hit = '0;
        for (int p = 0; p < 2; p++) begin
            if (wb_en_i[p]) wb_hit[wb_addr_i[p]] = 1'b1;
        end
        src_block = busy & ~wb_hit;
    end
`else
    assign src_block = busy;
`endif

    // RAW / WAW hazard detection per pipe plus intra-pair dependency
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            src_hit[p] = (id.src_use_i[p][0] & src_block[id.ra_i[p]])
                       | (id.src_use_i[p][1] & src_block[id.rb_i[p]])
                       | (id.src_use_i[p][2] & src_block[id.rc_i[p]]);
            rt_hit[p]  = id.we_i[p] & busy[id.rt_i[p]];
        end
        intra = id.valid_i[0] & id.we_i[0]
              & ((id.src_use_i[1][0] & (id.ra_i[1] == id.rt_i[0]))
               | (id.src_use_i[1][1] & (id.rb_i[1] == id.rt_i[0]))
               | (id.src_use_i[1][2] & (id.rc_i[1] == id.rt_i[0]))
               | (id.we_i[1] & (id.rt_i[1] == id.rt_i[0])));
        hz1 = id.valid_i[0] & (src_hit[0] | rt_hit[0]);
        hz2 = id.valid_i[1] & (src_hit[1] | rt_hit[1]);
    end

    // Issue FSM: next state, issue vector and stall
    always_comb begin
        state_n = state;
        issue   = '0;
        stall   = 1'b0;
        unique case (state)
            PAIR: begin
                if (hz1) begin
                    stall = 1'b1;
                end else if (hz2 | (id.valid_i[1] & intra)) begin
                    issue[0] = id.valid_i[0];
                    stall    = 1'b1;
                    state_n  = SPLIT;
                end else begin
                    issue = id.valid_i;
                end
            end
            SPLIT: begin
                if (hz2) begin
                    stall = 1'b1;
                end else begin
                    issue[1] = id.valid_i[1];
                    state_n  = PAIR;
                end
            end
        endcase
        if (flush_i) begin
            issue   = '0;
            state_n = PAIR;
        end
    end

    assign id.stall_o = stall;

    // Scoreboard: writeback clears, issue sets (set wins on same index)
    always_comb begin
        busy_n = busy;
        for (int p = 0; p < 2; p++) begin
            if (wb_en_i[p]) busy_n[wb_addr_i[p]] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            if (issue[p] && id.we_i[p]) busy_n[id.rt_i[p]] = 1'b1;
        end
    end

    // State and scoreboard registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PAIR;
            busy  <= '0;
        end else begin
            state <= state_n;
            busy  <= busy_n;
        end
    end

    // Execution-pipe output registers; non-issued pipes hold their fields
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_o <= '0;
            ex_opa_o   <= '0;
            ex_opb_o   <= '0;
            ex_opc_o   <= '0;
            ex_rt_o    <= '0;
            ex_we_o    <= '0;
            ex_ctrl_o  <= '0;
            ex_imm_o   <= '0;
        end else begin
            ex_valid_o <= issue;
            for (int p = 0; p < 2; p++) begin
                if (issue[p]) begin
                    ex_opa_o[p]  <= rd_data[3*p];
                    ex_opb_o[p]  <= rd_data[3*p+1];
                    ex_opc_o[p]  <= rd_data[3*p+2];
                    ex_rt_o[p]   <= id.rt_i[p];
                    ex_we_o[p]   <= id.we_i[p];
                    ex_ctrl_o[p] <= id.ctrl_i[p];
                    ex_imm_o[p]  <= id.imm_i[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_fetch_issue.sv
// Directed testbench for reg_fetch_issue (default build, no forwarding).
// Each task drives one scenario and checks its own expected values.
module tb_reg_fetch_issue;
    import spu_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush_i;
    logic [1:0]     wb_en_i;
    reg_idx_t [1:0] wb_addr_i;
    data_t [1:0]    wb_data_i;
    logic [1:0]     ex_valid_o;
    data_t [1:0]    ex_opa_o, ex_opb_o, ex_opc_o;
    reg_idx_t [1:0] ex_rt_o;
    logic [1:0]     ex_we_o;
    ctrl_t [1:0]    ex_ctrl_o;
    imm_t [1:0]     ex_imm_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam data_t ONES = '1;

    reg_fetch_issue_if id_bus ();

    reg_fetch_issue dut (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush_i),
        .id         (id_bus),
        .wb_en_i    (wb_en_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .ex_valid_o (ex_valid_o),
        .ex_opa_o   (ex_opa_o),
        .ex_opb_o   (ex_opb_o),
        .ex_opc_o   (ex_opc_o),
        .ex_rt_o    (ex_rt_o),
        .ex_we_o    (ex_we_o),
        .ex_ctrl_o  (ex_ctrl_o),
        .ex_imm_o   (ex_imm_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_bus.valid_i   = '0;
        id_bus.ra_i      = '0;
        id_bus.rb_i      = '0;
        id_bus.rc_i      = '0;
        id_bus.src_use_i = '0;
        id_bus.rt_i      = '0;
        id_bus.we_i      = '0;
        id_bus.ctrl_i    = '0;
        id_bus.imm_i     = '0;
        wb_en_i          = '0;
        wb_addr_i        = '0;
        wb_data_i        = '0;
        flush_i          = 1'b0;
    endtask

    task automatic set_pipe(input int p, input logic [6:0] ra,
                            input logic [6:0] rb, input logic [6:0] rc,
                            input logic [2:0] srcu, input logic [6:0] rt,
                            input logic we, input logic [3:0] ctrl,
                            input logic [17:0] imm);
        id_bus.valid_i[p]   = 1'b1;
        id_bus.ra_i[p]      = ra;
        id_bus.rb_i[p]      = rb;
        id_bus.rc_i[p]      = rc;
        id_bus.src_use_i[p] = srcu;
        id_bus.rt_i[p]      = rt;
        id_bus.we_i[p]      = we;
        id_bus.ctrl_i[p]    = ctrl;
        id_bus.imm_i[p]     = imm;
    endtask

    task automatic wb(input int p, input logic [6:0] a, input data_t d);
        wb_en_i[p]   = 1'b1;
        wb_addr_i[p] = a;
        wb_data_i[p] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 00", ex_valid_o);
        end
        n_checks++;
        if (ex_opa_o[0] !== '0 || ex_rt_o[1] !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: opa0 %h rt1 %h want 0", ex_opa_o[0], ex_rt_o[1]);
        end
        n_checks++;
        if (id_bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b want 0", id_bus.stall_o);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_pair();
        wb(0, 7'd5, 128'hA);
        wb(1, 7'd6, 128'hB);
        tick();
        idle();
        set_pipe(0, 7'd5, 7'd6, 7'd0, 3'b011, 7'd7, 1'b1, 4'h3, 18'h3FFFF);
        set_pipe(1, 7'd8, 7'd0, 7'd0, 3'b001, 7'd0, 1'b0, 4'h5, 18'h00001);
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_stall: got %b want 0", id_bus.stall_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_valid: got %b want 11", ex_valid_o);
        end
        n_checks++;
        if (ex_opa_o[0] !== 128'hA || ex_opb_o[0] !== 128'hB) begin
            n_fail++;
            $display("FAIL basic_ops: opa %h opb %h want a b", ex_opa_o[0], ex_opb_o[0]);
        end
        n_checks++;
        if (ex_rt_o[0] !== 7'd7 || ex_we_o !== 2'b01 || ex_imm_o[0] !== 18'h3FFFF
            || ex_ctrl_o[1] !== 4'h5) begin
            n_fail++;
            $display("FAIL basic_ctl: rt %0d we %b imm %h ctrl %h want 7 01 3ffff 5",
                     ex_rt_o[0], ex_we_o, ex_imm_o[0], ex_ctrl_o[1]);
        end
        idle();
        set_pipe(0, 7'd7, 7'd0, 7'd0, 3'b001, 7'd0, 1'b0, 4'h0, 18'h0);
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy7_stall: got %b want 1", id_bus.stall_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b00) begin
            n_fail++;
            $display("FAIL busy7_noissue: got %b want 00", ex_valid_o);
        end
        wb(0, 7'd7, 128'h77);
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy7_wbcycle: got %b want 1", id_bus.stall_o);
        end
        tick();
        wb_en_i = '0;
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL busy7_clear: got %b want 0", id_bus.stall_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b01 || ex_opa_o[0] !== 128'h77) begin
            n_fail++;
            $display("FAIL busy7_issue: valid %b opa %h want 01 77", ex_valid_o, ex_opa_o[0]);
        end
        idle();
    endtask

    task automatic test_intra_raw();
        set_pipe(0, 7'd5, 7'd0, 7'd0, 3'b001, 7'd9, 1'b1, 4'h1, 18'h0);
        set_pipe(1, 7'd9, 7'd0, 7'd0, 3'b001, 7'd10, 1'b0, 4'h2, 18'h0);
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL intra_stall0: got %b want 1", id_bus.stall_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b01 || ex_opa_o[0] !== 128'hA) begin
            n_fail++;
            $display("FAIL intra_p1: valid %b opa %h want 01 a", ex_valid_o, ex_opa_o[0]);
        end
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL intra_stall1: got %b want 1", id_bus.stall_o);
        end
        tick();
        wb(0, 7'd9, 128'h55);
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b00) begin
            n_fail++;
            $display("FAIL intra_wait: got %b want 00", ex_valid_o);
        end
        wb_en_i = '0;
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL intra_release: got %b want 0", id_bus.stall_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b10 || ex_opa_o[1] !== 128'h55) begin
            n_fail++;
            $display("FAIL intra_p2: valid %b opa %h want 10 55", ex_valid_o, ex_opa_o[1]);
        end
        n_checks++;
        if (ex_opa_o[0] !== 128'hA || ex_rt_o[0] !== 7'd9) begin
            n_fail++;
            $display("FAIL intra_hold: opa0 %h rt0 %0d want a 9", ex_opa_o[0], ex_rt_o[0]);
        end
        idle();
    endtask

    task automatic test_src_busy();
        set_pipe(0, 7'd5, 7'd0, 7'd0, 3'b001, 7'd3, 1'b1, 4'h0, 18'h0);
        tick();
        idle();
        set_pipe(0, 7'd3, 7'd0, 7'd0, 3'b001, 7'd11, 1'b1, 4'h0, 18'h0);
        set_pipe(1, 7'd6, 7'd0, 7'd0, 3'b001, 7'd0, 1'b0, 4'h0, 18'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (id_bus.stall_o !== 1'b1) begin
                n_fail++;
                $display("FAIL src_stall%0d: got %b want 1", i, id_bus.stall_o);
            end
            tick();
            n_checks++;
            if (ex_valid_o !== 2'b00) begin
                n_fail++;
                $display("FAIL src_hold%0d: got %b want 00", i, ex_valid_o);
            end
        end
        wb(0, 7'd3, 128'h33);
        tick();
        wb_en_i = '0;
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL src_release: got %b want 0", id_bus.stall_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b11 || ex_opa_o[0] !== 128'h33 || ex_opa_o[1] !== 128'hB) begin
            n_fail++;
            $display("FAIL src_issue: valid %b opa0 %h opa1 %h want 11 33 b",
                     ex_valid_o, ex_opa_o[0], ex_opa_o[1]);
        end
        idle();
        wb(0, 7'd11, 128'h11);
        tick();
        idle();
    endtask

    task automatic test_waw();
        set_pipe(0, 7'd5, 7'd0, 7'd0, 3'b001, 7'd12, 1'b1, 4'h0, 18'h0);
        set_pipe(1, 7'd6, 7'd0, 7'd0, 3'b001, 7'd12, 1'b1, 4'h0, 18'h0);
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_stall: got %b want 1", id_bus.stall_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b01) begin
            n_fail++;
            $display("FAIL waw_p1: got %b want 01", ex_valid_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b00) begin
            n_fail++;
            $display("FAIL waw_wait: got %b want 00", ex_valid_o);
        end
        wb(0, 7'd12, 128'h12);
        tick();
        wb_en_i = '0;
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b10 || ex_rt_o[1] !== 7'd12 || ex_opa_o[1] !== 128'hB) begin
            n_fail++;
            $display("FAIL waw_p2: valid %b rt %0d opa %h want 10 12 b",
                     ex_valid_o, ex_rt_o[1], ex_opa_o[1]);
        end
        idle();
        wb(0, 7'd12, 128'h12);
        tick();
        idle();
    endtask

    task automatic test_flush();
        set_pipe(0, 7'd5, 7'd0, 7'd0, 3'b001, 7'd13, 1'b1, 4'h0, 18'h0);
        set_pipe(1, 7'd13, 7'd0, 7'd0, 3'b001, 7'd0, 1'b0, 4'h0, 18'h0);
        tick();
        flush_i = 1'b1;
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_valid: got %b want 00", ex_valid_o);
        end
        idle();
        set_pipe(0, 7'd5, 7'd0, 7'd0, 3'b001, 7'd14, 1'b0, 4'h0, 18'h0);
        set_pipe(1, 7'd6, 7'd0, 7'd0, 3'b001, 7'd0, 1'b0, 4'h0, 18'h0);
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_pair: got %b want 11", ex_valid_o);
        end
        idle();
        set_pipe(0, 7'd13, 7'd0, 7'd0, 3'b001, 7'd0, 1'b0, 4'h0, 18'h0);
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_busy: got %b want 1", id_bus.stall_o);
        end
        idle();
        wb(0, 7'd13, 128'h13);
        tick();
        idle();
    endtask

    task automatic test_wb_ports();
        wb(0, 7'd20, 128'h1);
        wb(1, 7'd20, 128'h2);
        tick();
        idle();
        wb(0, 7'd127, ONES);
        wb(1, 7'd0, 128'h5A5A);
        tick();
        idle();
        id_bus.valid_i = 2'b00;
        set_pipe(1, 7'd20, 7'd127, 7'd0, 3'b111, 7'd0, 1'b0, 4'h0, 18'h0);
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL p2only_stall: got %b want 0", id_bus.stall_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b10) begin
            n_fail++;
            $display("FAIL p2only_valid: got %b want 10", ex_valid_o);
        end
        n_checks++;
        if (ex_opa_o[1] !== 128'h2) begin
            n_fail++;
            $display("FAIL wb_collide: got %h want 2", ex_opa_o[1]);
        end
        n_checks++;
        if (ex_opb_o[1] !== ONES || ex_opc_o[1] !== 128'h5A5A) begin
            n_fail++;
            $display("FAIL wb_edges: opb %h opc %h want all-ones 5a5a",
                     ex_opb_o[1], ex_opc_o[1]);
        end
        idle();
    endtask

    task automatic test_reset_split();
        set_pipe(0, 7'd5, 7'd0, 7'd0, 3'b001, 7'd4, 1'b1, 4'h7, 18'h0);
        set_pipe(1, 7'd4, 7'd0, 7'd0, 3'b001, 7'd0, 1'b0, 4'h0, 18'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (ex_valid_o !== 2'b00 || ex_opa_o[0] !== '0 || ex_rt_o[0] !== '0
            || ex_we_o !== 2'b00 || ex_ctrl_o[0] !== '0) begin
            n_fail++;
            $display("FAIL rst_split_out: valid %b opa %h rt %0d we %b ctrl %h want zeros",
                     ex_valid_o, ex_opa_o[0], ex_rt_o[0], ex_we_o, ex_ctrl_o[0]);
        end
        idle();
        set_pipe(0, 7'd4, 7'd0, 7'd0, 3'b001, 7'd15, 1'b1, 4'h0, 18'h0);
        set_pipe(1, 7'd6, 7'd0, 7'd0, 3'b001, 7'd0, 1'b0, 4'h0, 18'h0);
        #1;
        n_checks++;
        if (id_bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_split_stall: got %b want 0", id_bus.stall_o);
        end
        tick();
        n_checks++;
        if (ex_valid_o !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_split_pair: got %b want 11", ex_valid_o);
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_basic_pair();
        test_intra_raw();
        test_src_busy();
        test_waw();
        test_flush();
        test_wb_ports();
        test_reset_split();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
